// File: rtl/instr_prefetch.sv
// Sequential instruction prefetch buffer between a multi-cycle instruction memory and the core's instr port.
// Optional same-cycle forwarding of returning memory data is enabled with `define PREFETCH_BYPASS_EN.
module instr_prefetch #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        advance,
  output logic [31:0] instr,
  output logic        hit,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, REQ_STALE} state_t;

  state_t        state, state_nxt;
  logic [31:0]   head_addr, fa;
  logic [AW:0]   count, count_nxt;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   fifo_mem [DEPTH];

  logic redirect, fifo_hit, ack_live, bypass, issue, push, fifo_pop, pop;
  logic pc_unused;

  assign pc_unused = ^pc[1:0];

  assign redirect = pc[31:2] != head_addr[31:2];
  assign fifo_hit = (count != '0) && !redirect;
  // An ack that is not cancelled by a redirect in the same cycle carries usable data.
  assign ack_live = (state == REQ) && mem_ack && !redirect;

`ifdef PREFETCH_BYPASS_EN
  assign bypass = ack_live && (count == '0) && (mem_addr[31:2] == pc[31:2]);
`else
  assign bypass = 1'b0;
`endif

  assign hit      = fifo_hit | bypass;
  assign instr    = bypass ? mem_rdata : fifo_mem[rd_ptr];
  assign pop      = advance & hit;
  assign fifo_pop = advance & fifo_hit;
  // A forwarded word that the core consumes immediately never enters the queue.
  assign push     = ack_live & ~(bypass & advance);
  // In IDLE nothing is outstanding, so the current count is the full slot budget.
  assign issue    = (state == IDLE) && !redirect && (count < FULL);

  // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (issue) state_nxt = REQ;
      REQ:       if (mem_ack) state_nxt = IDLE;
                 else if (redirect) state_nxt = REQ_STALE;
      REQ_STALE: if (mem_ack) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (redirect) begin
      count_nxt = '0;
    end else begin
      unique case ({push, fifo_pop})
        2'b10:   count_nxt = count + (AW+1)'(1);
        2'b01:   count_nxt = count - (AW+1)'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      head_addr <= '0;
      fa        <= '0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;

      if (redirect) begin
        head_addr <= {pc[31:2], 2'b00};
        fa        <= {pc[31:2], 2'b00};
        rd_ptr    <= '0;
        wr_ptr    <= '0;
      end else begin
        if (pop)      head_addr <= head_addr + 32'd4;
        if (issue)    fa        <= fa + 32'd4;
        if (fifo_pop) rd_ptr    <= rd_ptr + AW'(1);
        if (push)     wr_ptr    <= wr_ptr + AW'(1);
      end

      if (issue) begin
        mem_req  <= 1'b1;
        mem_addr <= fa;
      end else if (mem_ack && (state != IDLE)) begin
        mem_req  <= 1'b0;
      end
    end
  end

  // NOTE: the data array has no reset; count and the pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata;
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: behavioural memory, scoreboarded core model, directed scenarios and a random phase.
// Compile with +define+PREFETCH_BYPASS_EN to exercise the forwarding build.
module tb_instr_prefetch;

  localparam int DEPTH = 4;
`ifdef PREFETCH_BYPASS_EN
  localparam int MISS_N = 2;
`else
  localparam int MISS_N = 3;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        advance = 1'b0;
  logic [31:0] pc = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] instr, mem_addr;
  logic        hit, mem_req;

  int errors = 0;
  int checks = 0;

  logic [31:0] req_log [$];
  logic [31:0] exp_q [$];
  bit          sb_en = 1'b0;
  bit          rand_lat = 1'b0;
  int          fixed_lat = 0;

  instr_prefetch #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pc(pc), .advance(advance),
    .instr(instr), .hit(hit), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory contents: a distinct word per word address; 0x20 holds a real MIPS lw encoding.
  function automatic logic [31:0] word(input logic [31:0] a);
    if (a[31:2] == 30'h8) return 32'h8C02_0000;
    return {a[31:2], 2'b01} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: acks after a per-request wait, returns word(addr), and checks the request stays stable.
  initial begin : memory
    bit          busy = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] cur_addr = '0;
    forever begin
      @(negedge clk);
      if (!reset || !mem_req) begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        busy      = 1'b0;
      end else begin
        if (!busy) begin
          busy     = 1'b1;
          cur_addr = mem_addr;
          wait_cnt = rand_lat ? $urandom_range(0, 3) : fixed_lat;
          req_log.push_back(mem_addr);
          check("mem_addr_align", {30'b0, mem_addr[1:0]}, 32'h0);
        end else begin
          check("mem_addr_hold", mem_addr, cur_addr);
        end
        if (wait_cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = word(mem_addr);
          busy      = 1'b0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 32'hDEAD_BEEF;
          wait_cnt--;
        end
      end
    end
  end

  // Monitor: any hit must present the word at pc; each commit pops the next expected instruction.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      if (reset && hit) begin
        check("hit_word", instr, word(pc));
        if (sb_en && advance) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_commit: got %h with no instruction expected", instr);
          end else begin
            check("sb_commit", instr, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic [31:0] start_pc);
    @(negedge clk);
    reset   = 1'b0;
    advance = 1'b0;
    pc      = start_pc;
    repeat (2) @(negedge clk);
    #2;
    check("rst_mem_req", mem_req, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_hit", hit, 32'h0);
    req_log.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One commit attempt; pc moves on only if the prefetcher hit.
  task automatic commit_one(output bit took);
    @(negedge clk);
    #1 advance = 1'b1;
    #1 took = hit;
    @(posedge clk);
    #1 advance = 1'b0;
    if (took) pc = pc + 32'd4;
  endtask

  // Core model: commits on hit, then steps or jumps; every new pc queues its expected word.
  task automatic run_core(input int n, input int adv_pct, input int jump_pct,
                          input int budget, input int max_gap);
    int commits = 0;
    int cyc = 0;
    int gap = 0;
    int maxg = 0;
    bit h;
    while (commits < n && cyc < budget) begin
      @(negedge clk);
      #1 advance = ($urandom_range(0, 99) < adv_pct);
      #1 h = hit;
      gap  = h ? 0 : gap + 1;
      if (gap > maxg) maxg = gap;
      @(posedge clk);
      #1;
      if (h && advance) begin
        commits++;
        if ($urandom_range(0, 99) < jump_pct) begin
          case ($urandom_range(0, 2))
            0:       pc = $urandom & 32'hFFFF_FFFC;
            1:       pc = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
            default: pc = $urandom_range(0, 63) << 2;
          endcase
        end else begin
          pc = pc + 32'd4;
        end
        exp_q.push_back(word(pc));
      end
      cyc++;
    end
    advance = 1'b0;
    check("core_commits", commits, n);
    if (max_gap >= 0) check("hit_gap_ok", (maxg <= max_gap), 32'h1);
  endtask

  initial begin : main
    int n;
    int bad;
    bit found;
    bit took;

    // Reset fetch: four sequential requests, then idle with the queue full.
    fixed_lat = 0;
    do_reset(32'h0);
    @(posedge clk);
    #1;
    check("first_req", mem_req, 32'h1);
    check("first_addr", mem_addr, 32'h0);
    repeat (12) @(negedge clk);
    #2;
    check("fill_req_count", req_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < req_log.size(); i++) check("fill_req_addr", req_log[i], 32'(i * 4));
    check("fill_mem_req", mem_req, 32'h0);
    check("fill_count", dut.count, 32'(DEPTH));
    check("fill_hit", hit, 32'h1);
    check("fill_instr", instr, word(32'h0));

    // Streaming: continuous advance, sequential pc.
    req_log.delete();
    exp_q.delete();
    exp_q.push_back(word(pc));
    sb_en = 1'b1;
    run_core(16, 100, 0, 200, 2);
    sb_en = 1'b0;
    bad = 0;
    for (int i = 1; i < req_log.size(); i++) if (req_log[i] != req_log[i-1] + 32'd4) bad++;
    check("stream_seq", bad, 32'h0);
    if (req_log.size() > 0) check("stream_first_req", req_log[0], 32'h10);

    // Redirect while idle with a full queue.
    do_reset(32'h0);
    repeat (12) @(negedge clk);
    #1 pc = 32'h40;
    req_log.delete();
    @(posedge clk);
    #1;
    check("redir_count", dut.count, 32'h0);
    n = 0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      #2;
      n++;
      found = hit;
    end
    check("redir_found_hit", found, 32'h1);
    check("miss_latency", n, 32'(MISS_N));
    check("redir_instr", instr, word(32'h40));
    if (req_log.size() > 0) check("redir_first_req", req_log[0], 32'h40);

    // Stale request: redirect while a slow request to 0x10 is outstanding.
    do_reset(32'h0);
    repeat (12) @(negedge clk);
    fixed_lat = 3;
    commit_one(took);
    check("stale_setup_commit", took, 32'h1);
    req_log.delete();
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      #2;
      found = mem_req;
    end
    check("stale_req_seen", found, 32'h1);
    check("stale_req_addr", mem_addr, 32'h10);
    #1 pc = 32'h100;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      #2;
      if (mem_req) check("stale_addr_hold", mem_addr, 32'h10);
      found = mem_ack;
    end
    check("stale_ack_seen", found, 32'h1);
    fixed_lat = 0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      #2;
      found = hit;
    end
    check("stale_hit_seen", found, 32'h1);
    check("stale_instr", instr, word(32'h100));
    check("stale_req_count_ok", (req_log.size() >= 2), 32'h1);
    if (req_log.size() >= 2) check("stale_next_req", req_log[1], 32'h100);

    // Wrap-around of the fetch and head addresses.
    do_reset(32'hFFFF_FFF8);
    repeat (14) @(negedge clk);
    check("wrap_req_count_ok", (req_log.size() >= 3), 32'h1);
    for (int i = 0; i < 3 && i < req_log.size(); i++)
      check("wrap_req_addr", req_log[i], 32'hFFFF_FFF8 + 32'(i * 4));
    commit_one(took);
    check("wrap_commit_f8", took, 32'h1);
    commit_one(took);
    check("wrap_commit_fc", took, 32'h1);
    @(negedge clk);
    #2;
    check("wrap_pc0_hit", hit, 32'h1);
    check("wrap_pc0_instr", instr, word(32'h0));
    check("wrap_head", dut.head_addr, 32'h0);

    // Forwarding case: empty queue, pc=0x20, ack with advance held high.
    do_reset(32'h20);
    advance = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      #2;
      found = mem_ack;
    end
    check("byp_ack_seen", found, 32'h1);
`ifdef PREFETCH_BYPASS_EN
    check("byp_hit", hit, 32'h1);
    check("byp_instr", instr, 32'h8C02_0000);
    @(posedge clk);
    #1 advance = 1'b0;
    check("byp_count", dut.count, 32'h0);
    check("byp_head", dut.head_addr, 32'h24);
`else
    check("nobyp_hit_ack", hit, 32'h0);
    @(posedge clk);
    #1 advance = 1'b0;
    @(negedge clk);
    #2;
    check("nobyp_hit_next", hit, 32'h1);
    check("nobyp_instr", instr, 32'h8C02_0000);
`endif

    // Random program flow with random memory latency.
    rand_lat = 1'b1;
    do_reset($urandom_range(0, 15) << 2);
    exp_q.delete();
    exp_q.push_back(word(pc));
    sb_en = 1'b1;
    run_core(300, 75, 12, 8000, -1);
    @(negedge clk);
    sb_en = 1'b0;
    check("sb_drain", exp_q.size(), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
